prbs7_stream_checker: RTL and testbench

PRBS7_STREAM_CHECKER -- requirements
Module: prbs7_stream_checker

---
 rtl/prbs7_stream_checker.sv | 133 +++++++++++++
 tb/tb_prbs7_stream_checker.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/prbs7_stream_checker.sv
// Self-synchronising PRBS7 (x^7+x^6+1) checker for a word-parallel sliced bit stream.
// It aligns on clean words, then counts checked bits and mismatches and drops lock on bursty words.
module prbs7_stream_checker #(
  parameter int unsigned N           = 16,
  parameter int unsigned LOCK_CYCLES = 8,
  parameter int unsigned LOSS_THRESH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clear,
  input  logic         data_valid,
  input  logic [N-1:0] data_in,
  output logic [1:0]   state,
  output logic         locked,
  output logic         err_flag,
  output logic [31:0]  err_count,
  output logic [39:0]  bit_count
);

  localparam int MW = $clog2(N + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ALIGN  = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t        state_reg;
  logic [6:0]    hist_reg;        // hist_reg[0] is the oldest bit, x[k-7] for the word's bit 0
  logic          hist_valid_reg;
  logic [LW-1:0] lock_cnt_reg;

  logic [N+6:0]  stream;
  logic [N-1:0]  err_bits;
  logic [MW-1:0] mis_cnt;
  logic [32:0]   err_sum;
  logic [40:0]   bit_sum;
  logic          word_zero;
  logic          too_many;

  assign stream = {data_in, hist_reg};

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_err
      assign err_bits[gi] = stream[gi+7] ^ stream[gi+1] ^ stream[gi];
    end
  endgenerate

  always_comb begin
    mis_cnt = '0;
    for (int i = 0; i < N; i++) begin
      mis_cnt = mis_cnt + MW'(err_bits[i]);
    end
  end

  assign err_sum   = {1'b0, err_count} + 33'(mis_cnt);
  assign bit_sum   = {1'b0, bit_count} + 41'(N);
  assign word_zero = (data_in == '0);
  assign too_many  = (32'(mis_cnt) > LOSS_THRESH);
  assign state     = state_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      locked         <= 1'b0;
      err_flag       <= 1'b0;
      err_count      <= '0;
      bit_count      <= '0;
      hist_reg       <= '0;
      hist_valid_reg <= 1'b0;
      lock_cnt_reg   <= '0;
    end else begin
      err_flag <= 1'b0;
      if (!en) begin
        state_reg <= IDLE;
        locked    <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg      <= ALIGN;
            hist_valid_reg <= 1'b0;
          end
          ALIGN: begin
            if (data_valid) begin
              hist_reg <= data_in[N-1 -: 7];
              if (!hist_valid_reg) begin
                hist_valid_reg <= 1'b1;
                lock_cnt_reg   <= '0;
              end else if (mis_cnt == '0 && !word_zero) begin
                // An all-zero word trivially satisfies the recurrence, so it never builds lock
                if (lock_cnt_reg == LW'(LOCK_CYCLES - 1)) begin
                  state_reg    <= LOCKED;
                  locked       <= 1'b1;
                  lock_cnt_reg <= '0;
                end else begin
                  lock_cnt_reg <= lock_cnt_reg + LW'(1);
                end
              end else begin
                lock_cnt_reg <= '0;
              end
            end
          end
          LOCKED: begin
            if (data_valid) begin
              hist_reg  <= data_in[N-1 -: 7];
              err_flag  <= (mis_cnt != '0);
              err_count <= err_sum[32] ? '1 : err_sum[31:0];
              bit_count <= bit_sum[40] ? '1 : bit_sum[39:0];
              if (too_many) begin
                state_reg    <= ALIGN;
                locked       <= 1'b0;
                lock_cnt_reg <= '0;
              end
            end
          end
          default: begin
            state_reg <= IDLE;
            locked    <= 1'b0;
          end
        endcase
      end
      // Clear wins over any increment made in the same cycle
      if (clear) begin
        err_count <= '0;
        bit_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prbs7_stream_checker.sv
// Directed bench for prbs7_stream_checker: table-driven per-cycle vectors plus
// hand-written sequences for long locked runs, counter saturation and async reset.
module tb_prbs7_stream_checker;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         clear;
  logic         data_valid;
  logic [N-1:0] data_in;
  logic [1:0]   state;
  logic         locked;
  logic         err_flag;
  logic [31:0]  err_count;
  logic [39:0]  bit_count;

  int checks = 0;
  int errors = 0;
  logic [6:0] gen;

  typedef struct {
    logic        en;
    logic        clr;
    logic        dv;
    logic        lit;   // 1: drive mask as data, 0: next PRBS word XOR mask
    logic [15:0] mask;
    logic [1:0]  st;
    logic        lk;
    logic        fl;
    logic [31:0] ec;
    logic [39:0] bc;
  } vec_t;

  vec_t lock_tbl[$];
  vec_t err_tbl[$];
  vec_t tail_tbl[$];

  always #5 clk = ~clk;

  prbs7_stream_checker #(.N(16), .LOCK_CYCLES(8), .LOSS_THRESH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .data_valid(data_valid),
    .data_in(data_in), .state(state), .locked(locked), .err_flag(err_flag),
    .err_count(err_count), .bit_count(bit_count)
  );

  function automatic vec_t mk(logic e, logic c, logic d, logic l, logic [15:0] m,
                              logic [1:0] s, logic k, logic f, logic [31:0] ec, logic [39:0] bc);
    vec_t v;
    v.en = e; v.clr = c; v.dv = d; v.lit = l; v.mask = m;
    v.st = s; v.lk = k; v.fl = f; v.ec = ec; v.bc = bc;
    return v;
  endfunction

  // x[k] = x[k-6] ^ x[k-7]; gen[0] holds x[k-7], gen[6] holds x[k-1]
  function automatic logic [N-1:0] prbs_word();
    logic [N-1:0] w;
    logic nb;
    w = '0;
    for (int j = 0; j < N; j++) begin
      nb   = gen[1] ^ gen[0];
      w[j] = nb;
      gen  = {nb, gen[6:1]};
    end
    return w;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st, input logic lk,
                            input logic fl, input logic [31:0] ec, input logic [39:0] bc);
    chk({tag, ".state"},     64'(state),     64'(st));
    chk({tag, ".locked"},    64'(locked),    64'(lk));
    chk({tag, ".err_flag"},  64'(err_flag),  64'(fl));
    chk({tag, ".err_count"}, 64'(err_count), 64'(ec));
    chk({tag, ".bit_count"}, 64'(bit_count), 64'(bc));
    $display("%s st=%0d lk=%0b fl=%0b ec=%0h bc=%0d", tag, state, locked, err_flag, err_count, bit_count);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs sampled 1 unit after the next edge.
  task automatic drive(input logic e, input logic c, input logic d, input logic l, input logic [15:0] m);
    en = e; clear = c; data_valid = d;
    data_in = l ? m : (prbs_word() ^ m);
    @(posedge clk);
    #1;
  endtask

  task automatic run_tbl(input string prefix, input vec_t tbl[$]);
    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].dv, tbl[i].lit, tbl[i].mask);
      check_outs($sformatf("%s%0d", prefix, i), tbl[i].st, tbl[i].lk, tbl[i].fl, tbl[i].ec, tbl[i].bc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unl;

    // Lock-up: IDLE exit, prime, 7 clean words in ALIGN, 8th clean word locks
    for (int i = 0; i < 9; i++) lock_tbl.push_back(mk(1,0,1,0,16'h0, 2'd1,0,0,32'd0,40'd0));
    lock_tbl.push_back(mk(1,0,1,0,16'h0, 2'd2,1,0,32'd0,40'd0));

    // Error handling while locked, starting from ec=0, bc=1600
    err_tbl.push_back(mk(1,0,1,0,16'h0100, 2'd2,1,1,32'd3, 40'd1616)); // flip bit 8: M=3 in one word
    err_tbl.push_back(mk(1,0,1,0,16'h0000, 2'd2,1,0,32'd3, 40'd1632));
    err_tbl.push_back(mk(1,0,1,0,16'h1000, 2'd2,1,1,32'd4, 40'd1648)); // flip bit 12: M=1 here
    err_tbl.push_back(mk(1,0,1,0,16'h0000, 2'd2,1,1,32'd6, 40'd1664)); // ... and M=2 spills over
    err_tbl.push_back(mk(1,0,1,0,16'h0000, 2'd2,1,0,32'd6, 40'd1680));
    err_tbl.push_back(mk(1,0,0,1,16'hA5A5, 2'd2,1,0,32'd6, 40'd1680)); // data_valid=0: no change
    err_tbl.push_back(mk(1,0,1,0,16'h0003, 2'd2,1,1,32'd10,40'd1696)); // M=4 == threshold: stays
    err_tbl.push_back(mk(1,0,1,0,16'h003F, 2'd1,0,1,32'd18,40'd1712)); // M=8: drop to ALIGN
    for (int i = 0; i < 7; i++) err_tbl.push_back(mk(1,0,1,0,16'h0, 2'd1,0,0,32'd18,40'd1712));
    err_tbl.push_back(mk(1,0,1,0,16'h0000, 2'd2,1,0,32'd18,40'd1712)); // relock, no prime needed
    err_tbl.push_back(mk(1,1,1,0,16'h0100, 2'd2,1,1,32'd0, 40'd0));    // clear beats errored word
    err_tbl.push_back(mk(1,0,1,0,16'h0000, 2'd2,1,0,32'd0, 40'd16));

    // en=0 discard, clear in IDLE, all-zero input never locks
    tail_tbl.push_back(mk(0,0,1,0,16'h0000, 2'd0,0,0,32'hFFFF_FFFF,40'd32));
    tail_tbl.push_back(mk(0,1,0,1,16'h0000, 2'd0,0,0,32'd0,40'd0));
    for (int i = 0; i < 21; i++) tail_tbl.push_back(mk(1,0,1,1,16'h0, 2'd1,0,0,32'd0,40'd0));
    tail_tbl.push_back(mk(0,0,0,1,16'h0000, 2'd0,0,0,32'd0,40'd0));

    gen = 7'h7F;
    rst = 1'b1; en = 1'b0; clear = 1'b0; data_valid = 1'b0; data_in = '0;
    @(posedge clk); @(posedge clk); #1;
    check_outs("reset", 2'd0, 0, 0, 32'd0, 40'd0);
    rst = 1'b0;
    drive(0,0,1,1,16'h1234);
    check_outs("idle_hold", 2'd0, 0, 0, 32'd0, 40'd0);

    run_tbl("lock", lock_tbl);

    unl = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1,0,1,0,16'h0);
      if (locked !== 1'b1) unl++;
    end
    $display("run100 unlocked_cycles=%0d bc=%0d ec=%0d", unl, bit_count, err_count);
    chk("run100.unlocked_cycles", 64'(unl), 64'd0);
    chk("run100.bit_count", 64'(bit_count), 64'd1600);
    chk("run100.err_count", 64'(err_count), 64'd0);

    run_tbl("err", err_tbl);

    // Saturation: preload err_count, then a word with M=5 (also > threshold)
    force dut.err_count = 32'hFFFF_FFFE;
    #1;
    release dut.err_count;
    drive(1,0,1,0,16'h0007);
    check_outs("sat", 2'd1, 0, 1, 32'hFFFF_FFFF, 40'd32);

    run_tbl("tail", tail_tbl);

    run_tbl("relock", lock_tbl);
    drive(1,0,1,0,16'h0100);
    check_outs("pre_rst", 2'd2, 1, 1, 32'd3, 40'd16);

    // Async reset mid-cycle while data_valid toggles
    en = 1'b1; data_valid = 1'b0; data_in = 16'hFFFF;
    #3;
    rst = 1'b1;
    #1;
    check_outs("rst_async", 2'd0, 0, 0, 32'd0, 40'd0);
    data_valid = 1'b1; data_in = prbs_word();
    @(posedge clk); #1;
    check_outs("rst_held", 2'd0, 0, 0, 32'd0, 40'd0);
    rst = 1'b0;

    run_tbl("postrst", lock_tbl);
    drive(1,0,1,0,16'h0);
    check_outs("postrst_count", 2'd2, 1, 0, 32'd0, 40'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
